// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and constants for the two-requester memory access arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Access counter is sized for the largest supported MEM_LAT.
    localparam int unsigned MEM_LAT_MAX = 15;
    localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/mem_access_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic Req0,
    input  logic Req1,
    input  logic Last,
    output logic Valid,
    output logic Winner
);

    always_comb begin
        Valid  = Req0 | Req1;
        Winner = (Req0 & Req1) ? ~Last : Req1;
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between two requesters.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              RW0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    input  logic              Req1,
    input  logic              RW1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              Done0,
    output logic              Done1,
    output logic [DATA_W-1:0] RData,
    output logic              Busy,
    output logic              AccessMem,
    output logic              RWMem,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                win_q, win_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                busy_q, busy_d;
    logic                access_q, access_d;
    logic                rwmem_q, rwmem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                pick_valid;
    logic                pick_winner;
    logic                cnt_last;

    rr_pick2 u_pick (
        .Req0   (Req0),
        .Req1   (Req1),
        .Last   (last_q),
        .Valid  (pick_valid),
        .Winner (pick_winner)
    );

    assign cnt_last = (cnt_q == LAST_CNT);

    // State register (all registered outputs and datapath latches live here too)
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
            access_q <= 1'b0;
            rwmem_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            win_q    <= win_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
            access_q <= access_d;
            rwmem_q  <= rwmem_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (pick_valid) state_d = ST_ACCESS;
            ST_ACCESS: if (cnt_last)   state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        cnt_d    = cnt_q;
        last_d   = last_q;
        win_d    = win_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        busy_d   = busy_q;
        access_d = access_q;
        rwmem_d  = rwmem_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                busy_d   = 1'b0;
                access_d = 1'b0;
                if (pick_valid) begin
                    win_d    = pick_winner;
                    gnt0_d   = ~pick_winner;
                    gnt1_d   = pick_winner;
                    busy_d   = 1'b1;
                    access_d = 1'b1;
                    cnt_d    = '0;
                    rwmem_d  = pick_winner ? RW1    : RW0;
                    addr_d   = pick_winner ? Addr1  : Addr0;
                    wdata_d  = pick_winner ? WData1 : WData0;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // Memory data is only valid in the final strobe cycle, so capture here.
                if (cnt_last) begin
                    cnt_d    = '0;
                    access_d = 1'b0;
                    done0_d  = ~win_q;
                    done1_d  = win_q;
                    if (rwmem_q == RW_READ) rdata_d = MemRData;
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
                last_d = win_q;
            end
            default: begin
                busy_d   = 1'b0;
                access_d = 1'b0;
            end
        endcase
    end

    assign Gnt0      = gnt0_q;
    assign Gnt1      = gnt1_q;
    assign Done0     = done0_q;
    assign Done1     = done1_q;
    assign RData     = rdata_q;
    assign Busy      = busy_q;
    assign AccessMem = access_q;
    assign RWMem     = rwmem_q;
    assign MemAddr   = addr_q;
    assign MemWData  = wdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: a transaction-level model predicts grants and
// completions; a monitor checks the DUT against the queued predictions every cycle.
module tb_mem_access_arbiter;

    localparam int L = 2;

    logic       Clk   = 1'b0;
    logic       Reset = 1'b1;
    bit         req [2];
    bit         rw  [2];
    logic [7:0] addr  [2];
    logic [7:0] wdata [2];

    logic       Req0, RW0, Req1, RW1;
    logic [7:0] Addr0, WData0, Addr1, WData1;
    logic       Gnt0, Gnt1, Done0, Done1, Busy, AccessMem, RWMem;
    logic [7:0] RData, MemAddr, MemWData, MemRData;

    assign Req0 = req[0];  assign RW0 = rw[0];  assign Addr0 = addr[0];  assign WData0 = wdata[0];
    assign Req1 = req[1];  assign RW1 = rw[1];  assign Addr1 = addr[1];  assign WData1 = wdata[1];

    always #5 Clk = ~Clk;

    mem_access_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(L)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .RW0(RW0), .Addr0(Addr0), .WData0(WData0),
        .Req1(Req1), .RW1(RW1), .Addr1(Addr1), .WData1(WData1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
        .RData(RData), .Busy(Busy), .AccessMem(AccessMem), .RWMem(RWMem),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData)
    );

    // Behavioural memory array attached to the DUT's memory port
    logic [7:0] tb_mem [256];
    bit         mem_ready = 1'b0;
    always @(posedge Clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= 8'(i) ^ 8'h99;
            mem_ready <= 1'b1;
        end else if (AccessMem && !RWMem) begin
            tb_mem[MemAddr] <= MemWData;
        end
    end
    assign MemRData = tb_mem[MemAddr];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit         w;
        bit         rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         e;
    } txn_t;

    txn_t       gq[$];
    txn_t       dq[$];
    bit         m_last;
    int         m_free;
    logic [7:0] m_rdata;
    logic [7:0] ref_mem [256];
    bit         just_granted [2];

    // Transaction-level prediction for the upcoming edge cyc+1
    task automatic model_eval();
        txn_t t;
        int   e;
        e = cyc + 1;
        if (Reset || e < m_free || !(req[0] || req[1])) return;
        t.w     = (req[0] && req[1]) ? !m_last : req[1];
        t.rw    = rw[t.w];
        t.addr  = addr[t.w];
        t.wdata = wdata[t.w];
        t.e     = e;
        if (t.rw) m_rdata = ref_mem[t.addr];
        else      ref_mem[t.addr] = t.wdata;
        t.rdata = m_rdata;
        gq.push_back(t);
        t.e = e + L;
        dq.push_back(t);
        m_free = e + L + 2;
        m_last = t.w;
        just_granted[t.w] = 1'b1;
    endtask

    task automatic tick();
        model_eval();
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rand_fields(input int r);
        rw[r]    = ($urandom_range(0, 1) == 1);
        addr[r]  = 8'($urandom_range(0, 15));
        wdata[r] = 8'($urandom);
    endtask

    task automatic do_reset();
        #1 Reset = 1'b1;
        req[0] = 1'b0;
        req[1] = 1'b0;
        #1;
        chk("rst_async_gnt",    32'({Gnt1, Gnt0}), 0);
        chk("rst_async_done",   32'({Done1, Done0}), 0);
        chk("rst_async_busy",   32'({Busy, AccessMem}), 0);
        chk("rst_async_rdata",  32'(RData), 0);
        chk("rst_async_memout", 32'({RWMem, MemAddr, MemWData}), 0);
        gq.delete();
        dq.delete();
        m_last  = 1'b1;
        m_rdata = '0;
        just_granted[0] = 1'b0;
        just_granted[1] = 1'b0;
        tick();
        tick();
        Reset  = 1'b0;
        m_free = cyc + 1;
    endtask

    // Monitor: pops predictions when due and checks every output each cycle
    txn_t cur;
    txn_t d;
    int   cur_g = -100;
    always @(posedge Clk) begin
        #1;
        if (Reset) begin
            cur_g = -100;
            chk("rst_outputs", 32'({Gnt0, Gnt1, Done0, Done1, Busy, AccessMem, RWMem,
                                    MemAddr, MemWData, RData}), 0);
        end else begin
            if (gq.size() > 0 && gq[0].e == cyc) begin
                cur   = gq.pop_front();
                cur_g = cyc;
                chk("gnt_id", 32'({Gnt1, Gnt0}), cur.w ? 2 : 1);
            end else begin
                chk("gnt_none", 32'({Gnt1, Gnt0}), 0);
            end
            if (cyc >= cur_g && cyc < cur_g + L) begin
                chk("access_on", 32'(AccessMem), 1);
                chk("mem_addr",  32'(MemAddr), 32'(cur.addr));
                chk("mem_rw",    32'(RWMem), 32'(cur.rw));
                chk("mem_wdata", 32'(MemWData), 32'(cur.wdata));
            end else begin
                chk("access_off", 32'(AccessMem), 0);
            end
            chk("busy", 32'(Busy), (cyc >= cur_g && cyc <= cur_g + L) ? 1 : 0);
            if (dq.size() > 0 && dq[0].e == cyc) begin
                d = dq.pop_front();
                chk("done_id", 32'({Done1, Done0}), d.w ? 2 : 1);
                chk("rdata",   32'(RData), 32'(d.rdata));
            end else begin
                chk("done_none", 32'({Done1, Done0}), 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h99;
        for (int r = 0; r < 2; r++) begin
            req[r] = 1'b0; rw[r] = 1'b0; addr[r] = '0; wdata[r] = '0;
        end
        @(negedge Clk);
        do_reset();

        // First tie after reset goes to requester 0
        rw[0] = 1'b1; addr[0] = 8'h01; rw[1] = 1'b1; addr[1] = 8'h02;
        req[0] = 1'b1; req[1] = 1'b1;
        tick();
        req[0] = 1'b0; req[1] = 1'b0;
        idle(L + 3);

        // Single read of 0x3C returns 0xA5
        rw[0] = 1'b1; addr[0] = 8'h3C; req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        idle(L + 3);

        // Write then read-back on requester 1
        rw[1] = 1'b0; addr[1] = 8'h10; wdata[1] = 8'h5A; req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        idle(L + 3);
        rw[1] = 1'b1; req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        idle(L + 3);

        // Fairness: both held continuously
        just_granted[0] = 1'b0; just_granted[1] = 1'b0;
        rand_fields(0); rand_fields(1);
        req[0] = 1'b1; req[1] = 1'b1;
        for (int i = 0; i < 6 * (L + 2); i++) begin
            for (int r = 0; r < 2; r++)
                if (just_granted[r]) begin just_granted[r] = 1'b0; rand_fields(r); end
            tick();
        end
        req[0] = 1'b0; req[1] = 1'b0;
        idle(L + 3);

        // Reset during the second access cycle, then a tie
        rw[0] = 1'b1; rw[1] = 1'b1; req[0] = 1'b1; req[1] = 1'b1;
        tick();
        tick();
        do_reset();
        req[0] = 1'b1; req[1] = 1'b1;
        tick();
        req[0] = 1'b0; req[1] = 1'b0;
        idle(L + 3);

        // Request 1 withdrawn during requester 0's access
        rw[0] = 1'b1; addr[0] = 8'h22; req[0] = 1'b1;
        tick();
        req[0] = 1'b0; req[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        idle(L + 3);

        // Randomized traffic
        just_granted[0] = 1'b0; just_granted[1] = 1'b0;
        for (int i = 0; i < 600; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (just_granted[r]) begin
                    just_granted[r] = 1'b0;
                    rand_fields(r);
                    req[r] = ($urandom_range(0, 1) == 1);
                end else if (!req[r]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[r] = 1'b1;
                        rand_fields(r);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req[r] = 1'b0;
                end
            end
            tick();
        end
        req[0] = 1'b0; req[1] = 1'b0;
        for (int i = 0; i < 20 && (gq.size() > 0 || dq.size() > 0); i++) tick();
        chk("drain_pending", 32'(gq.size() + dq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
